// File: rtl/calc_display_pkg.sv
// Shared types and segment encodings for the calculator result display.
// Segment constants are active-high {g,f,e,d,c,b,a}.
package calc_display_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CONVERT,
      ST_LOAD
   } state_t;

   localparam int NUM_DIGITS = 6;
   localparam int BCD_W      = 20;

   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };
   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_MINUS = 7'h40;
   localparam logic [6:0] SEG_E     = 7'h79;
   localparam logic [6:0] SEG_R     = 7'h50;

   function automatic logic [6:0] seg_digit(input logic [3:0] nib);
      return (nib <= 4'd9) ? SEG_DIGIT[nib] : SEG_BLANK;
   endfunction

endpackage

// File: rtl/bin16_to_bcd_seq.sv
// Sequential double-dabble: 16-bit binary to five BCD digits in 16 cycles.
// done_o is high during the final iteration cycle; bcd_o is final after that edge.
module bin16_to_bcd_seq
   import calc_display_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start_i,
   input  logic [15:0]        abs_i,
   output logic               done_o,
   output logic [BCD_W-1:0]   bcd_o
);

   logic [15:0]      bin_q, bin_d;
   logic [BCD_W-1:0] bcd_q, bcd_d, bcd_adj;
   logic [3:0]       cnt_q;
   logic             active_q;

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < BCD_W / 4; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bin_q    <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else if (start_i) begin
         bin_q    <= abs_i;
         bcd_q    <= '0;
         cnt_q    <= 4'd15;
         active_q <= 1'b1;
      end else if (active_q) begin
         bin_q <= bin_d;
         bcd_q <= bcd_d;
         cnt_q <= cnt_q - 4'd1;
         if (cnt_q == 4'd0) active_q <= 1'b0;
      end
   end

   assign done_o = active_q && (cnt_q == 4'd0);
   assign bcd_o  = bcd_q;

endmodule

// File: rtl/result_display_driver.sv
// Converts the selected result to a sign + 5-digit (or "Err") image and scans it
// onto a shared active-low 7-segment bus.
//   state      | meaning
//   ST_IDLE    | display held; watch for a new or changed result
//   ST_CONVERT | double-dabble running (16 cycles)
//   ST_LOAD    | commit image, set ready
module result_display_driver
   import calc_display_pkg::*;
#(
   parameter int REFRESH_DIV = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] abs_in,
   input  logic        neg,
   input  logic        err,
   output logic [6:0]  seg,
   output logic [5:0]  an,
   output logic        busy,
   output logic        ready
);

   localparam int SCAN_W = $clog2(REFRESH_DIV);

   state_t             state_q;
   logic [17:0]        snap_q;
   logic [6:0]         image_q [NUM_DIGITS];
   logic [6:0]         img_d   [NUM_DIGITS];
   logic               ready_q, busy_q;
   logic [SCAN_W-1:0]  scan_q;
   logic [2:0]         idx_q;
   logic [6:0]         seg_q;
   logic [5:0]         an_q;
   logic               start_d, conv_start, conv_done, nz_seen;
   logic [BCD_W-1:0]   bcd;

   assign start_d    = (state_q == ST_IDLE) && (enable || err) &&
                       (!ready_q || ({err, neg, abs_in} != snap_q));
   assign conv_start = start_d && !err;

   bin16_to_bcd_seq u_conv (
      .clk     (clk),
      .reset   (reset),
      .start_i (conv_start),
      .abs_i   (abs_in),
      .done_o  (conv_done),
      .bcd_o   (bcd)
   );

   // Image built from the snapshot taken at start, so late input changes cannot leak in.
   always_comb begin
      nz_seen = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) img_d[i] = SEG_BLANK;
      if (snap_q[17]) begin
         img_d[2] = SEG_E;
         img_d[1] = SEG_R;
         img_d[0] = SEG_R;
      end else begin
         for (int i = 4; i >= 1; i--) begin
            nz_seen  = nz_seen | (bcd[4*i +: 4] != 4'd0);
            img_d[i] = nz_seen ? seg_digit(bcd[4*i +: 4]) : SEG_BLANK;
         end
         img_d[0] = seg_digit(bcd[3:0]);
         img_d[5] = (snap_q[16] && (snap_q[15:0] != 16'd0)) ? SEG_MINUS : SEG_BLANK;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         snap_q  <= '0;
         image_q <= '{default: SEG_BLANK};
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_d) begin
                  snap_q  <= {err, neg, abs_in};
                  busy_q  <= 1'b1;
                  state_q <= err ? ST_LOAD : ST_CONVERT;
               end
            end
            ST_CONVERT: begin
               if (conv_done) state_q <= ST_LOAD;
            end
            ST_LOAD: begin
               image_q <= img_d;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Outputs reload only at the start of each digit slot, so a commit never shows mid-digit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scan_q <= '0;
         idx_q  <= '0;
         seg_q  <= 7'h7F;
         an_q   <= 6'h3F;
      end else begin
         if (scan_q == SCAN_W'(REFRESH_DIV - 1)) begin
            scan_q <= '0;
            idx_q  <= (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
         end else begin
            scan_q <= scan_q + SCAN_W'(1);
         end
         if (scan_q == '0) begin
            an_q  <= ~(6'd1 << idx_q);
            seg_q <= ready_q ? ~image_q[idx_q] : ~SEG_BLANK;
         end
      end
   end

   assign seg   = seg_q;
   assign an    = an_q;
   assign busy  = busy_q;
   assign ready = ready_q;

endmodule

// File: tb/tb_result_display_driver.sv
// Bench for result_display_driver: decimal-arithmetic display model compared every
// cycle, plus literal digit checks for the directed scenarios.
module tb_result_display_driver;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        neg = 1'b0;
   logic        err = 1'b0;
   logic [15:0] abs_in = 16'd0;
   logic [6:0]  seg;
   logic [5:0]  an;
   logic        busy, ready;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   result_display_driver #(.REFRESH_DIV(DIV)) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .abs_in (abs_in),
      .neg    (neg),
      .err    (err),
      .seg    (seg),
      .an     (an),
      .busy   (busy),
      .ready  (ready)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model (edge-indexed, decimal arithmetic) ----------------
   int          e;
   bit          m_ready, m_pending;
   int          m_commit;
   bit [17:0]   m_snap;
   logic [6:0]  m_img  [6];
   logic [6:0]  m_pend [6];
   logic [6:0]  exp_seg;
   logic [5:0]  exp_an;
   logic        exp_busy;
   bit          model_on = 1'b0;

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
         4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
         8: return 7'h7F;  default: return 7'h6F;
      endcase
   endfunction

   function automatic void build(input bit er, input bit ng, input int v);
      int pw [5] = '{1, 10, 100, 1000, 10000};
      for (int i = 0; i < 6; i++) m_pend[i] = 7'h00;
      if (er) begin
         m_pend[2] = 7'h79;
         m_pend[1] = 7'h50;
         m_pend[0] = 7'h50;
      end else begin
         for (int i = 0; i < 5; i++)
            m_pend[i] = (i == 0 || v >= pw[i]) ? seg_of((v / pw[i]) % 10) : 7'h00;
         m_pend[5] = (ng && v != 0) ? 7'h40 : 7'h00;
      end
   endfunction

   function automatic void model_reset();
      e = 0;
      m_ready = 0;
      m_pending = 0;
      m_commit = 0;
      m_snap = '0;
      for (int i = 0; i < 6; i++) m_img[i] = 7'h00;
      exp_seg = 7'h7F;
      exp_an = 6'h3F;
      exp_busy = 1'b0;
   endfunction

   always @(negedge reset) model_reset();

   always @(posedge clk) begin
      if (reset) begin
         int idx;
         e++;
         if ((e - 1) % DIV == 0) begin
            idx = ((e - 1) / DIV) % 6;
            exp_an  = ~(6'd1 << idx);
            exp_seg = ~(m_ready ? m_img[idx] : 7'h00);
         end
         if (m_pending && e == m_commit) begin
            m_img = m_pend;
            m_ready = 1'b1;
            m_pending = 1'b0;
         end else if (!m_pending && (enable || err) &&
                      (!m_ready || {err, neg, abs_in} != m_snap)) begin
            m_snap = {err, neg, abs_in};
            build(err, neg, int'(abs_in));
            m_pending = 1'b1;
            m_commit = e + (err ? 1 : 17);
         end
         exp_busy = m_pending;
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         chk("model seg", seg, exp_seg);
         chk("model an", an, exp_an);
         chk("model busy", busy, exp_busy);
         chk("model ready", ready, m_ready);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic see_digit(input string nm, input logic [5:0] pat, input logic [6:0] want);
      int k = 0;
      @(negedge clk);
      while (an !== pat && k < 8 * DIV) begin
         @(negedge clk);
         k++;
      end
      chk({nm, " an"}, an, pat);
      chk(nm, seg, want);
   endtask

   task automatic settle();
      int k = 0;
      repeat (3) @(negedge clk);
      while (busy === 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("settle busy", busy, 0);
      repeat (7 * DIV) @(negedge clk);
   endtask

   task automatic drive(input bit en, input bit er, input bit ng, input logic [15:0] v);
      @(posedge clk);
      #1;
      enable = en;
      err    = er;
      neg    = ng;
      abs_in = v;
   endtask

   initial begin
      int cnt;
      model_reset();
      model_on = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst seg", seg, 7'h7F);
      chk("rst an", an, 6'h3F);
      chk("rst busy", busy, 0);
      chk("rst ready", ready, 0);
      @(posedge clk);
      #1 reset = 1'b1;

      // 1: 12345
      drive(1, 0, 0, 16'd12345);
      cnt = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (busy === 1'b1) cnt++;
      end
      chk("t1 busy cycles", cnt, 17);
      chk("t1 ready", ready, 1);
      see_digit("t1 d5", 6'b011111, 7'h7F);
      see_digit("t1 d4", 6'b101111, 7'h79);
      see_digit("t1 d0", 6'b111110, 7'h12);

      // 2: -7, then -0
      drive(1, 0, 1, 16'd7);
      settle();
      see_digit("t2 d5 minus", 6'b011111, 7'b0111111);
      see_digit("t2 d4 blank", 6'b101111, 7'h7F);
      see_digit("t2 d0", 6'b111110, 7'h78);
      drive(1, 0, 1, 16'd0);
      settle();
      see_digit("t2 zero d5", 6'b011111, 7'h7F);
      see_digit("t2 zero d0", 6'b111110, 7'h40);

      // 3: -32768
      drive(1, 0, 1, 16'h8000);
      settle();
      see_digit("t3 d5", 6'b011111, 7'b0111111);
      see_digit("t3 d4", 6'b101111, 7'h30);
      see_digit("t3 d0", 6'b111110, 7'h00);

      // 4: error
      drive(0, 1, 0, 16'd0);
      @(posedge clk);
      @(negedge clk);
      chk("t4 busy start", busy, 1);
      @(negedge clk);
      chk("t4 busy done", busy, 0);
      settle();
      see_digit("t4 E", 6'b111011, 7'h06);
      see_digit("t4 r", 6'b111101, 7'h2F);
      see_digit("t4 d3 blank", 6'b110111, 7'h7F);

      // 5: change mid-conversion
      drive(1, 0, 0, 16'd65535);
      cnt = 0;
      for (int c = 0; c < 60; c++) begin
         @(posedge clk);
         if (c == 5) begin
            #1 abs_in = 16'd1;
         end
         @(negedge clk);
         if (busy === 1'b1) cnt++;
      end
      chk("t5 busy cycles", cnt, 34);
      see_digit("t5 d0", 6'b111110, 7'h79);
      see_digit("t5 d1 blank", 6'b111101, 7'h7F);
      cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (busy === 1'b1) cnt++;
      end
      chk("t5 hold busy", cnt, 0);

      // 6: reset mid-conversion
      drive(1, 0, 0, 16'd500);
      @(posedge clk);
      repeat (8) @(posedge clk);
      #1 reset = 1'b0;
      enable = 1'b0;
      #1;
      chk("t6 seg", seg, 7'h7F);
      chk("t6 an", an, 6'h3F);
      chk("t6 busy", busy, 0);
      chk("t6 ready", ready, 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (30) @(negedge clk);
      chk("t6 no commit", ready, 0);
      drive(1, 0, 0, 16'd500);
      settle();
      see_digit("t6 d2", 6'b111011, 7'h12);
      see_digit("t6 d0", 6'b111110, 7'h40);

      model_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
